// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared segment, code and anode constants for the display mux
package display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0          = 7'h40;
  localparam logic [6:0] SEG_1          = 7'h79;
  localparam logic [6:0] SEG_2          = 7'h24;
  localparam logic [6:0] SEG_3          = 7'h30;
  localparam logic [6:0] SEG_4          = 7'h19;
  localparam logic [6:0] SEG_5          = 7'h12;
  localparam logic [6:0] SEG_6          = 7'h02;
  localparam logic [6:0] SEG_7          = 7'h78;
  localparam logic [6:0] SEG_8          = 7'h00;
  localparam logic [6:0] SEG_9          = 7'h10;
  localparam logic [6:0] SEG_UNDERSCORE = 7'h77;
  localparam logic [6:0] SEG_BLANK      = 7'h7F;

  localparam logic [4:0] CODE_UNDERSCORE = 5'h1F;
  localparam logic [3:0] AN_OFF          = 4'b1111;

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - 5-bit digit code to active-low seven-segment pattern
module seg_decoder
  import display_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      5'd0:            o_seg = SEG_0;
      5'd1:            o_seg = SEG_1;
      5'd2:            o_seg = SEG_2;
      5'd3:            o_seg = SEG_3;
      5'd4:            o_seg = SEG_4;
      5'd5:            o_seg = SEG_5;
      5'd6:            o_seg = SEG_6;
      5'd7:            o_seg = SEG_7;
      5'd8:            o_seg = SEG_8;
      5'd9:            o_seg = SEG_9;
      CODE_UNDERSCORE: o_seg = SEG_UNDERSCORE;
      default:         o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// rtl/seg_display_mux.sv - 4-digit multiplexed seven-segment driver with per-scan capture
// Optional: LEADING_ZERO_BLANK_EN blanks leading zeros on the three left digits.
module seg_display_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [4:0] bcd3,
  input  logic [4:0] bcd2,
  input  logic [4:0] bcd1,
  input  logic [4:0] bcd0,
  input  logic       si,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int             CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [4:0]    r_sh3, r_sh2, r_sh1, r_sh0;
  logic          r_sh_si;
  logic          r_load_pending;

  logic          w_slot_end;
  logic          w_capture;
  logic          w_blank_slot;
  logic [4:0]    w_code;
  logic [6:0]    w_dec_seg;
  logic          w_lz_blank;

  assign w_slot_end   = (r_cnt == CNT_LAST);
  // Capture at the end of the last slot so every scan shows one consistent input set
  assign w_capture    = r_load_pending || (w_slot_end && (r_idx == 2'd3));
  assign w_blank_slot = (int'(r_cnt) < BLANK_CYCLES);

  always_comb begin
    w_code = r_sh3;
    case (r_idx)
      2'd0: w_code = r_sh3;
      2'd1: w_code = r_sh2;
      2'd2: w_code = r_sh1;
      2'd3: w_code = r_sh0;
      default: w_code = r_sh3;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_z3, w_z2, w_z1;
  assign w_z3 = (r_sh3 == 5'd0);
  assign w_z2 = w_z3 && (r_sh2 == 5'd0);
  assign w_z1 = w_z2 && (r_sh1 == 5'd0);

  always_comb begin
    w_lz_blank = 1'b0;
    case (r_idx)
      2'd0: w_lz_blank = w_z3;
      2'd1: w_lz_blank = w_z2;
      2'd2: w_lz_blank = w_z1;
      default: w_lz_blank = 1'b0;
    endcase
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  seg_decoder u_seg_decoder (
    .i_code (w_code),
    .o_seg  (w_dec_seg)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_cnt          <= '0;
      r_idx          <= 2'd0;
      r_sh3          <= 5'd0;
      r_sh2          <= 5'd0;
      r_sh1          <= 5'd0;
      r_sh0          <= 5'd0;
      r_sh_si        <= 1'b0;
      r_load_pending <= 1'b1;
      an             <= AN_OFF;
      seg            <= SEG_BLANK;
      dp             <= 1'b1;
    end else begin
      r_cnt          <= w_slot_end ? '0 : r_cnt + 1'b1;
      r_load_pending <= 1'b0;
      if (w_slot_end) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_capture) begin
        r_sh3   <= bcd3;
        r_sh2   <= bcd2;
        r_sh1   <= bcd1;
        r_sh0   <= bcd0;
        r_sh_si <= si;
      end
      // Outputs reflect the pre-edge cnt/idx/shadow, hence the one-cycle lag
      if (w_blank_slot) begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b1000 >> r_idx);
        seg <= w_lz_blank ? SEG_BLANK : w_dec_seg;
        dp  <= ~((r_idx == 2'd3) && r_sh_si);
      end
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// tb/tb_seg_display_mux.sv - randomized scoreboard bench for seg_display_mux
module tb_seg_display_mux;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int SCAN  = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] bcd3 = 5'd1, bcd2 = 5'd2, bcd1 = 5'd3, bcd0 = 5'd4;
  logic       si = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int passed = 0;

  logic [11:0] exp_q[$];
  logic [6:0]  digit_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seg_display_mux #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .sys_clk (clk),
    .reset   (reset),
    .bcd3    (bcd3),
    .bcd2    (bcd2),
    .bcd1    (bcd1),
    .bcd0    (bcd0),
    .si      (si),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [4:0] code);
    if (code < 5'd10) return digit_tbl[code];
    if (code == 5'h1F) return 7'h77;
    return 7'h7F;
  endfunction

  // Reference: position in the scan is pure arithmetic on cycles since reset release
  initial begin
    int          n;
    int          cnt;
    int          idx;
    logic [4:0]  m_sh [4];
    logic        m_si;
    logic [3:0]  blanked;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    n = 0;
    m_si = 1'b0;
    for (int k = 0; k < 4; k++) m_sh[k] = 5'd0;
    forever begin
      @(posedge clk);
      if (reset) begin
        n = 0;
        m_si = 1'b0;
        for (int k = 0; k < 4; k++) m_sh[k] = 5'd0;
        exp_q.push_back({4'b1111, 7'h7F, 1'b1});
      end else begin
        cnt = n % DIV;
        idx = (n / DIV) % 4;
        blanked = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        blanked[0] = (m_sh[0] == 5'd0);
        blanked[1] = blanked[0] && (m_sh[1] == 5'd0);
        blanked[2] = blanked[1] && (m_sh[2] == 5'd0);
`endif
        if (cnt < BLANK) begin
          e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
          e_an = 4'b1111;
          e_an[3 - idx] = 1'b0;
          e_seg = blanked[idx] ? 7'h7F : ref_seg(m_sh[idx]);
          e_dp = !(idx == 3 && m_si);
        end
        exp_q.push_back({e_an, e_seg, e_dp});
        if (n == 0 || (n % SCAN) == SCAN - 1) begin
          m_sh[0] = bcd3; m_sh[1] = bcd2; m_sh[2] = bcd1; m_sh[3] = bcd0;
          m_si = si;
        end
        n++;
      end
    end
  end

  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({an, seg, dp} === e) passed++;
        else $display("FAIL out_chk t=%0t got an=%b seg=%h dp=%b exp an=%b seg=%h dp=%b",
                      $time, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [4:0] d, input logic s);
    bcd3 = a; bcd2 = b; bcd1 = c; bcd0 = d; si = s;
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    tick(2 * SCAN);
    set_in(5'd0, 5'd5, 5'h1F, 5'd5, 1'b0);  tick(2 * SCAN);
    set_in(5'd0, 5'd10, 5'h10, 5'd9, 1'b0); tick(2 * SCAN);
    set_in(5'd1, 5'd2, 5'd3, 5'd4, 1'b1);   tick(SCAN + 6);
    si = 1'b0;                              tick(2 * SCAN);
    set_in(5'd1, 5'd2, 5'd3, 5'd7, 1'b0);   tick(2 * SCAN);
    set_in(5'd0, 5'd0, 5'd0, 5'd0, 1'b0);   tick(2 * SCAN);
    set_in(5'd0, 5'h1F, 5'd0, 5'd3, 1'b1);  tick(2 * SCAN);
    reset = 1'b1; tick(2);
    reset = 1'b0; tick(10);
    reset = 1'b1; tick(1);
    reset = 1'b0; tick(SCAN);
    for (int i = 0; i < 150; i++) begin
      logic [4:0] c [4];
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) c[k] = 5'($urandom_range(0, 31));
        else if ($urandom_range(0, 2) == 0) c[k] = 5'd0;
        else c[k] = 5'($urandom_range(0, 9));
      end
      set_in(c[0], c[1], c[2], c[3], 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b1; tick($urandom_range(1, 3));
        reset = 1'b0;
      end
      tick($urandom_range(1, 24));
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain got %0d pending exp 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
